// File: rtl/stack_pkg.sv
// Shared constants for the data stack and the control block that drives it.
// Holds the stackOP encodings and the default word width and depth.
package stack_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_BINOP   = 3'b011;
    localparam logic [2:0] OP_REPLACE = 3'b100;
    localparam logic [2:0] OP_DUP     = 3'b101;
    localparam logic [2:0] OP_SWAP    = 3'b110;
    localparam logic [2:0] OP_OVER    = 3'b111;

endpackage

// File: rtl/data_stack_if.sv
// Bus between the control/data-memory stage and the data stack.
// master drives the operation and write data; slave is the stack.
interface data_stack_if #(
    parameter int WIDTH = 16,
    parameter int PTR_W = 5
);
    logic [2:0]       stackOP;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [PTR_W-1:0] depth;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output stackOP, din,
        input  top, next, depth, empty, full, overflow, underflow
    );

    modport slave (
        input  stackOP, din,
        output top, next, depth, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH storage with two async read ports and two sync write ports.
// No reset: contents are meaningful only below the depth held by the parent.
module stack_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic [AW-1:0]    i_raddr0,
    input  logic [AW-1:0]    i_raddr1,
    output logic [WIDTH-1:0] o_rdata0,
    output logic [WIDTH-1:0] o_rdata1,
    input  logic             i_we0,
    input  logic [AW-1:0]    i_waddr0,
    input  logic [WIDTH-1:0] i_wdata0,
    input  logic             i_we1,
    input  logic [AW-1:0]    i_waddr1,
    input  logic [WIDTH-1:0] i_wdata1
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // The parent never enables both ports on the same address.
    always_ff @(posedge i_clk) begin
        if (i_we0) r_mem[i_waddr0] <= i_wdata0;
        if (i_we1) r_mem[i_waddr1] <= i_wdata1;
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];
endmodule

// File: rtl/data_stack.sv
// Hardware data stack: depth counter, operation legality checks, sticky
// overflow/underflow flags and depth-gated top/next outputs.
module data_stack
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input logic         CLK,
    input logic         reset,
    data_stack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);

    logic [PTR_W-1:0] r_depth;
    logic             r_ovf;
    logic             r_unf;

    logic [PTR_W-1:0] w_depth_nxt;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic [AW-1:0]    w_idx_new;
    logic [AW-1:0]    w_idx_top;
    logic [AW-1:0]    w_idx_nxt;
    logic             w_ge1;
    logic             w_ge2;
    logic             w_at_max;
    logic [WIDTH-1:0] w_rd_top;
    logic [WIDTH-1:0] w_rd_nxt;
    logic             w_we0;
    logic [AW-1:0]    w_wa0;
    logic [WIDTH-1:0] w_wd0;
    logic             w_we1;
    logic [AW-1:0]    w_wa1;
    logic [WIDTH-1:0] w_wd1;

    assign w_idx_new = r_depth[AW-1:0];
    assign w_idx_top = w_idx_new - AW'(1);
    assign w_idx_nxt = w_idx_new - AW'(2);
    assign w_ge1     = (r_depth != '0);
    assign w_ge2     = (r_depth >= PTR_W'(2));
    assign w_at_max  = (r_depth == C_DEPTH);

    stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
        .i_clk    (CLK),
        .i_raddr0 (w_idx_top),
        .i_raddr1 (w_idx_nxt),
        .o_rdata0 (w_rd_top),
        .o_rdata1 (w_rd_nxt),
        .i_we0    (w_we0),
        .i_waddr0 (w_wa0),
        .i_wdata0 (w_wd0),
        .i_we1    (w_we1),
        .i_waddr1 (w_wa1),
        .i_wdata1 (w_wd1)
    );

    // Rejected operations leave array and depth untouched and only raise a flag.
    always_comb begin
        w_depth_nxt = r_depth;
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        w_we0       = 1'b0;
        w_wa0       = w_idx_new;
        w_wd0       = bus.din;
        w_we1       = 1'b0;
        w_wa1       = w_idx_nxt;
        w_wd1       = w_rd_top;
        unique case (bus.stackOP)
            OP_PUSH: begin
                if (w_at_max) w_set_ovf = 1'b1;
                else begin
                    w_we0       = 1'b1;
                    w_depth_nxt = r_depth + PTR_W'(1);
                end
            end
            OP_POP: begin
                if (!w_ge1) w_set_unf = 1'b1;
                else w_depth_nxt = r_depth - PTR_W'(1);
            end
            OP_BINOP: begin
                if (!w_ge2) w_set_unf = 1'b1;
                else begin
                    w_we0       = 1'b1;
                    w_wa0       = w_idx_nxt;
                    w_depth_nxt = r_depth - PTR_W'(1);
                end
            end
            OP_REPLACE: begin
                if (!w_ge1) w_set_unf = 1'b1;
                else begin
                    w_we0 = 1'b1;
                    w_wa0 = w_idx_top;
                end
            end
            OP_DUP: begin
                // Empty takes precedence: DUP on an empty stack is an underflow.
                if (!w_ge1) w_set_unf = 1'b1;
                else if (w_at_max) w_set_ovf = 1'b1;
                else begin
                    w_we0       = 1'b1;
                    w_wd0       = w_rd_top;
                    w_depth_nxt = r_depth + PTR_W'(1);
                end
            end
            OP_SWAP: begin
                if (!w_ge2) w_set_unf = 1'b1;
                else begin
                    w_we0 = 1'b1;
                    w_wa0 = w_idx_top;
                    w_wd0 = w_rd_nxt;
                    w_we1 = 1'b1;
                end
            end
            OP_OVER: begin
                if (!w_ge2) w_set_unf = 1'b1;
                else if (w_at_max) w_set_ovf = 1'b1;
                else begin
                    w_we0       = 1'b1;
                    w_wd0       = w_rd_nxt;
                    w_depth_nxt = r_depth + PTR_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_depth <= w_depth_nxt;
            if (w_set_ovf) r_ovf <= 1'b1;
            if (w_set_unf) r_unf <= 1'b1;
        end
    end

    assign bus.top       = w_ge1 ? w_rd_top : '0;
    assign bus.next      = w_ge2 ? w_rd_nxt : '0;
    assign bus.depth     = r_depth;
    assign bus.empty     = !w_ge1;
    assign bus.full      = w_at_max;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: directed vector table, hand-written
// corner sequences and a model-driven random run through a scoreboard queue.
module tb_data_stack;
    import stack_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] din;
        logic [15:0] top;
        logic [15:0] nxt;
        logic [4:0]  depth;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        unf;
    } vec_t;

    logic CLK;
    logic reset;

    data_stack_if #(.WIDTH(16), .PTR_W(5)) bus ();

    data_stack #(.WIDTH(16), .DEPTH(16), .PTR_W(5)) u_dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   n_vec;
    int   n_err;
    vec_t sb[$];

    // Reference model state
    logic [15:0] m_mem [16];
    int          m_d;
    logic        m_ovf;
    logic        m_unf;

    function automatic vec_t mk(logic [2:0] op, logic [15:0] din, logic [15:0] t,
                                logic [15:0] n, logic [4:0] d, logic o, logic u);
        vec_t v;
        v.op = op; v.din = din; v.top = t; v.nxt = n; v.depth = d;
        v.empty = (d == 5'd0); v.full = (d == 5'd16); v.ovf = o; v.unf = u;
        return v;
    endfunction

    task automatic compare(string name, vec_t e);
        n_vec++;
        if (bus.top !== e.top || bus.next !== e.nxt || bus.depth !== e.depth ||
            bus.empty !== e.empty || bus.full !== e.full ||
            bus.overflow !== e.ovf || bus.underflow !== e.unf) begin
            n_err++;
            $display("FAIL %s: got top=%h next=%h depth=%0d empty=%b full=%b ovf=%b unf=%b, want top=%h next=%h depth=%0d empty=%b full=%b ovf=%b unf=%b",
                     name, bus.top, bus.next, bus.depth, bus.empty, bus.full,
                     bus.overflow, bus.underflow, e.top, e.nxt, e.depth,
                     e.empty, e.full, e.ovf, e.unf);
        end
    endtask

    // Drive one operation, queue its expected result, compare after the edge.
    task automatic step(string name, vec_t e);
        vec_t got;
        bus.stackOP = e.op;
        bus.din     = e.din;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        compare(name, got);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        m_d = 0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    // Model: spec-level behaviour, returns the expected record for op/din.
    function automatic vec_t model_step(logic [2:0] op, logic [15:0] din);
        vec_t        e;
        logic [15:0] a, b;
        case (op)
            OP_PUSH:    if (m_d == 16) m_ovf = 1'b1; else begin m_mem[m_d] = din; m_d++; end
            OP_POP:     if (m_d < 1) m_unf = 1'b1; else m_d--;
            OP_BINOP:   if (m_d < 2) m_unf = 1'b1; else begin m_mem[m_d-2] = din; m_d--; end
            OP_REPLACE: if (m_d < 1) m_unf = 1'b1; else m_mem[m_d-1] = din;
            OP_DUP: begin
                if (m_d < 1) m_unf = 1'b1;
                else if (m_d == 16) m_ovf = 1'b1;
                else begin m_mem[m_d] = m_mem[m_d-1]; m_d++; end
            end
            OP_SWAP: begin
                if (m_d < 2) m_unf = 1'b1;
                else begin
                    a = m_mem[m_d-1]; b = m_mem[m_d-2];
                    m_mem[m_d-1] = b; m_mem[m_d-2] = a;
                end
            end
            OP_OVER: begin
                if (m_d < 2) m_unf = 1'b1;
                else if (m_d == 16) m_ovf = 1'b1;
                else begin m_mem[m_d] = m_mem[m_d-2]; m_d++; end
            end
            default: ;
        endcase
        e = mk(op, din, (m_d >= 1) ? m_mem[m_d-1] : 16'h0,
               (m_d >= 2) ? m_mem[m_d-2] : 16'h0, 5'(m_d), m_ovf, m_unf);
        return e;
    endfunction

    vec_t tbl[$];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.stackOP = OP_NOP;
        bus.din = 16'h0;
        #2;
        do_reset();
        #1;
        compare("reset_state", mk(OP_NOP, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0));

        // Directed table, applied from reset.
        tbl.push_back(mk(OP_PUSH,    16'h1234, 16'h1234, 16'h0000, 5'd1, 0, 0));
        tbl.push_back(mk(OP_PUSH,    16'h00FF, 16'h00FF, 16'h1234, 5'd2, 0, 0));
        tbl.push_back(mk(OP_SWAP,    16'hAAAA, 16'h1234, 16'h00FF, 5'd2, 0, 0));
        tbl.push_back(mk(OP_BINOP,   16'h1333, 16'h1333, 16'h0000, 5'd1, 0, 0));
        tbl.push_back(mk(OP_NOP,     16'hFFFF, 16'h1333, 16'h0000, 5'd1, 0, 0));
        tbl.push_back(mk(OP_POP,     16'h5555, 16'h0000, 16'h0000, 5'd0, 0, 0));
        tbl.push_back(mk(OP_PUSH,    16'hBEEF, 16'hBEEF, 16'h0000, 5'd1, 0, 0));
        tbl.push_back(mk(OP_DUP,     16'h1111, 16'hBEEF, 16'hBEEF, 5'd2, 0, 0));
        tbl.push_back(mk(OP_OVER,    16'h2222, 16'hBEEF, 16'hBEEF, 5'd3, 0, 0));
        tbl.push_back(mk(OP_REPLACE, 16'h0001, 16'h0001, 16'hBEEF, 5'd3, 0, 0));
        tbl.push_back(mk(OP_SWAP,    16'h3333, 16'hBEEF, 16'h0001, 5'd3, 0, 0));
        tbl.push_back(mk(OP_POP,     16'h0000, 16'h0001, 16'hBEEF, 5'd2, 0, 0));
        tbl.push_back(mk(OP_POP,     16'h0000, 16'hBEEF, 16'h0000, 5'd1, 0, 0));
        tbl.push_back(mk(OP_POP,     16'h0000, 16'h0000, 16'h0000, 5'd0, 0, 0));
        tbl.push_back(mk(OP_POP,     16'h0000, 16'h0000, 16'h0000, 5'd0, 0, 1));
        tbl.push_back(mk(OP_PUSH,    16'h5555, 16'h5555, 16'h0000, 5'd1, 0, 1));
        tbl.push_back(mk(OP_SWAP,    16'h0000, 16'h5555, 16'h0000, 5'd1, 0, 1));
        tbl.push_back(mk(OP_BINOP,   16'h9999, 16'h5555, 16'h0000, 5'd1, 0, 1));
        tbl.push_back(mk(OP_OVER,    16'h0000, 16'h5555, 16'h0000, 5'd1, 0, 1));
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("table[%0d]", i), tbl[i]);

        // Fill to DEPTH, then overflow cases, then POP out of full.
        do_reset();
        for (int i = 0; i < 16; i++)
            step($sformatf("fill[%0d]", i),
                 mk(OP_PUSH, 16'(i), 16'(i), (i >= 1) ? 16'(i - 1) : 16'h0, 5'(i + 1), 0, 0));
        step("push_at_full", mk(OP_PUSH, 16'hDEAD, 16'h000F, 16'h000E, 5'd16, 1, 0));
        step("dup_at_full",  mk(OP_DUP,  16'h0000, 16'h000F, 16'h000E, 5'd16, 1, 0));
        step("over_at_full", mk(OP_OVER, 16'h0000, 16'h000F, 16'h000E, 5'd16, 1, 0));
        step("pop_from_full", mk(OP_POP, 16'h0000, 16'h000E, 16'h000D, 5'd15, 1, 0));

        // DUP on empty raises only underflow.
        do_reset();
        step("dup_empty",  mk(OP_DUP, 16'h0000, 16'h0000, 16'h0000, 5'd0, 0, 1));
        step("push_after", mk(OP_PUSH, 16'h7777, 16'h7777, 16'h0000, 5'd1, 0, 1));

        // Asynchronous reset mid-cycle with a PUSH presented at depth 5.
        do_reset();
        for (int i = 0; i < 5; i++)
            step($sformatf("pre_rst[%0d]", i),
                 mk(OP_PUSH, 16'h100 + 16'(i), 16'h100 + 16'(i),
                    (i >= 1) ? 16'h100 + 16'(i - 1) : 16'h0, 5'(i + 1), 0, 0));
        step("pre_rst_pop_empty_ok", mk(OP_NOP, 16'h0, 16'h0104, 16'h0103, 5'd5, 0, 0));
        bus.stackOP = OP_PUSH;
        bus.din     = 16'hCAFE;
        #2;
        reset = 1'b1;
        #1;
        compare("async_reset_now", mk(OP_PUSH, 16'h0, 16'h0, 16'h0, 5'd0, 0, 0));
        @(posedge CLK);
        #1;
        compare("held_in_reset", mk(OP_PUSH, 16'h0, 16'h0, 16'h0, 5'd0, 0, 0));
        #2;
        reset = 1'b0;
        m_d = 0; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge CLK);
        #1;
        compare("resume_push", mk(OP_PUSH, 16'hCAFE, 16'hCAFE, 16'h0, 5'd1, 0, 0));
        step("resume_push2", mk(OP_PUSH, 16'hF00D, 16'hF00D, 16'hCAFE, 5'd2, 0, 0));

        // Random run against the model, biased toward pushes to reach full.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  op;
            logic [15:0] d;
            int          r;
            r  = int'($urandom_range(0, 9));
            op = (r >= 8) ? OP_PUSH : 3'(r);
            d  = 16'($urandom);
            step($sformatf("rand[%0d]", i), model_step(op, d));
            if (i == 200) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_stack.md
Name: data_stack

Overview:
Hardware data stack that sits directly downstream of the control/data-memory stage. Each cycle it consumes the 3-bit stackOP from control and the 16-bit stackWriteData from the stack-control mux (immediate, shifted immediate, memory read data, or input-port data). It applies the operation on the rising edge of CLK. It exposes the top two entries to the ALU and to memory address/write-data paths, and reports its depth and any fault conditions.

Parameters:
WIDTH, 16, data word width in bits.
DEPTH, 16, number of entries; must be a power of two and at least 4.
PTR_W, 5, depth-counter width, equal to log2(DEPTH)+1, so the counter can hold the value DEPTH.

Ports:
CLK  input  1  system clock; all state updates occur on the rising edge.
reset  input  1  asynchronous, active-high reset.
stackOP  input  3  operation select; encodings are listed under Behaviour.
din  input  WIDTH  write data; connects to stackWriteData.
top  output  WIDTH  entry at depth-1; 0 when depth==0.
next  output  WIDTH  entry at depth-2; 0 when depth<2.
depth  output  PTR_W  current number of valid entries.
empty  output  1  asserted when depth==0.
full  output  1  asserted when depth==DEPTH.
overflow  output  1  sticky flag; set by a rejected operation that would exceed DEPTH.
underflow  output  1  sticky flag; set by a rejected operation that lacks enough operands.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-operation):
  - depth=0, overflow=0, underflow=0.
  - Storage array is not cleared. top and next read 0 because they are gated by depth.
- Read path is combinational from the array and depth; there are no read-latency cycles.
- Write path: an operation presented in cycle N becomes visible on top/next/depth in cycle N+1.
- stackOP encodings and depth requirements (d = depth before the edge):
  - 000 NOP: no change.
  - 001 PUSH: requires d<DEPTH. mem[d]<=din; d+1.
  - 010 POP: requires d>=1. d-1.
  - 011 BINOP (ALU result replaces two operands): requires d>=2. mem[d-2]<=din; d-1.
  - 100 REPLACE (unary result): requires d>=1. mem[d-1]<=din; depth unchanged.
  - 101 DUP: requires 1<=d<DEPTH. mem[d]<=mem[d-1]; d+1.
  - 110 SWAP: requires d>=2. mem[d-1] and mem[d-2] exchanged; depth unchanged.
  - 111 OVER: requires 2<=d<DEPTH. mem[d]<=mem[d-2]; d+1.
- Rejected operation: if a requirement fails, there is no change to the array or depth.
  - Set overflow if the failure is due to the depth limit (d==DEPTH on PUSH, DUP or OVER).
  - Otherwise set underflow.
  - If both conditions hold (DUP with d==0), set only underflow.
- Sticky flags clear only on reset.
- full and empty are combinational decodes of depth.
- No wrap-around: depth saturates at 0 and DEPTH through the rejection rule above; the counter never rolls over.
- Arithmetic: depth updates use PTR_W-bit unsigned arithmetic. Array indices use the low log2(DEPTH) bits.
- din is sampled only for PUSH, BINOP and REPLACE; it is ignored for all other operations.

Decomposition:
- Shared package stack_pkg holds:
  - localparams for the stackOP encodings: OP_NOP, OP_PUSH, OP_POP, OP_BINOP, OP_REPLACE, OP_DUP, OP_SWAP, OP_OVER. The control block uses the same constants.
  - WIDTH default.
- One sub-module is natural: stack_regfile.
  - DEPTH x WIDTH register array, no reset.
  - Two asynchronous read ports.
  - Two synchronous write ports, required by SWAP.
  - Write-port priority is irrelevant because the two write addresses are always distinct.
- data_stack holds the depth counter, the legality checks, the sticky flags, and the output gating.

Test Plan:
1. Reset, then PUSH din=0x1234, then PUSH 0x00FF -> top=0x00FF, next=0x1234, depth=2, empty=0.
2. From scenario 1, apply SWAP -> top=0x1234, next=0x00FF. Then BINOP din=0x1333 -> top=0x1333, depth=1, next=0.
3. Start at depth=1 with top=0xBEEF. DUP -> depth=2, top=next=0xBEEF. Then OVER -> depth=3, top=0xBEEF. Then REPLACE 0x0001 -> top=0x0001, depth=3.
4. PUSH DEPTH times (values 0..15) -> full=1, top=0x000F. A 17th PUSH -> depth remains 16, top=0x000F, overflow=1, underflow=0. A subsequent POP -> depth=15 and overflow stays 1.
5. From reset, POP -> depth=0, underflow=1, top=0. Then SWAP at depth=1 -> rejected, depth unchanged.
6. Assert reset asynchronously mid-cycle while depth=5 and a PUSH is presented -> depth=0, overflow=underflow=0, top=0 immediately, before the next CLK edge. Operation resumes correctly after reset deasserts.
